// File: rtl/instr_encoder_loader_pkg.sv
// Shared definitions for the instruction loader: command kind codes, MIPS
// opcode/funct constants (same values the main control decoder uses), the
// loader FSM state type, and helpers that pack R/I/J instruction formats.
package instr_encoder_loader_pkg;

    localparam logic [3:0] KIND_ADD   = 4'd0;
    localparam logic [3:0] KIND_SUB   = 4'd1;
    localparam logic [3:0] KIND_ADDU  = 4'd2;
    localparam logic [3:0] KIND_SLT   = 4'd3;
    localparam logic [3:0] KIND_OR    = 4'd4;
    localparam logic [3:0] KIND_AND   = 4'd5;
    localparam logic [3:0] KIND_ORI   = 4'd6;
    localparam logic [3:0] KIND_ADDIU = 4'd7;
    localparam logic [3:0] KIND_LW    = 4'd8;
    localparam logic [3:0] KIND_SW    = 4'd9;
    localparam logic [3:0] KIND_BEQ   = 4'd10;
    localparam logic [3:0] KIND_J     = 4'd11;
    localparam logic [3:0] KIND_ADDI  = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_ADDU = 6'b100001;
    localparam logic [5:0] FUNCT_SLT  = 6'b101010;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } loadState_t;

    function automatic logic [31:0] encR(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/instr_encode_comb.sv
// Pure combinational encoder: command kind + fields -> 32-bit MIPS word.
// Ports:
//   kind, rs, rt, rd, imm, target : symbolic command fields
//   word      : encoded instruction (0 when kind is invalid)
//   wordValid : 1 when kind is one of the 13 supported codes
module instr_encode_comb
    import instr_encoder_loader_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        wordValid
);

    always_comb begin
        word      = '0;
        wordValid = 1'b1;
        case (kind)
            KIND_ADD:   word = encR(rs, rt, rd, FUNCT_ADD);
            KIND_SUB:   word = encR(rs, rt, rd, FUNCT_SUB);
            KIND_ADDU:  word = encR(rs, rt, rd, FUNCT_ADDU);
            KIND_SLT:   word = encR(rs, rt, rd, FUNCT_SLT);
            KIND_OR:    word = encR(rs, rt, rd, FUNCT_OR);
            KIND_AND:   word = encR(rs, rt, rd, FUNCT_AND);
            KIND_ORI:   word = encI(OP_ORI, rs, rt, imm);
            KIND_ADDIU: word = encI(OP_ADDIU, rs, rt, imm);
            KIND_LW:    word = encI(OP_LW, rs, rt, imm);
            KIND_SW:    word = encI(OP_SW, rs, rt, imm);
            KIND_BEQ:   word = encI(OP_BEQ, rs, rt, imm);
            KIND_J:     word = {OP_J, target};
            KIND_ADDI:  word = encI(OP_ADDI, rs, rt, imm);
            default:    wordValid = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Instruction loader: accepts symbolic commands on a valid/ready stream,
// encodes them to MIPS words, writes them sequentially into imem starting at
// base, then reads the region back and compares an XOR checksum.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   start, base              : open a session at word address base (IDLE/DONE only)
//   cmd_valid/cmd_ready      : command handshake (ready only while RUN)
//   cmd_kind..cmd_last       : command fields, cmd_last closes the session
//   im_we/im_re/im_addr      : imem write / readback strobes and address
//   im_wdata, im_rdata       : imem write data, read data (1 cycle after im_re)
//   count                    : words written this session
//   done, verify_ok          : session finished, checksum matched
//   err_kind, err_ovf        : sticky invalid-kind / address-space overflow
module instr_encoder_loader
    import instr_encoder_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_kind,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    input  logic              cmd_last,
    output logic              im_we,
    output logic              im_re,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    input  logic [31:0]       im_rdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              verify_ok,
    output logic              err_kind,
    output logic              err_ovf
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);

    loadState_t        state, stateNext;
    logic [31:0]       word;
    logic              wordValid;
    logic              accept;
    logic              startTake;
    logic [ADDR_W:0]   countNext;
    logic              lastRead;

    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] baseReg;
    logic              full;
    logic [31:0]       csum;
    logic [31:0]       acc;
    logic [ADDR_W:0]   rdOffset;
    logic [ADDR_W:0]   rdCount;
    logic              vld_p1;

    instr_encode_comb encoder (
        .kind      (cmd_kind),
        .rs        (cmd_rs),
        .rt        (cmd_rt),
        .rd        (cmd_rd),
        .imm       (cmd_imm),
        .target    (cmd_target),
        .word      (word),
        .wordValid (wordValid)
    );

    assign cmd_ready = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign accept    = cmd_valid && cmd_ready;
    assign startTake = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign countNext = count + {{ADDR_W{1'b0}}, wordValid};
    assign lastRead  = vld_p1 && ((rdCount + CNT_ONE) == count);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) stateNext = ST_RUN;
            end
            ST_RUN: begin
                if (accept) begin
                    // Overflow wins over cmd_last; an empty session skips readback.
                    if (full)                                stateNext = ST_DONE;
                    else if (cmd_last && countNext == '0)    stateNext = ST_DONE;
                    else if (cmd_last)                       stateNext = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (lastRead) stateNext = ST_DONE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            im_we     <= 1'b0;
            im_re     <= 1'b0;
            im_addr   <= '0;
            im_wdata  <= '0;
            count     <= '0;
            verify_ok <= 1'b0;
            err_kind  <= 1'b0;
            err_ovf   <= 1'b0;
            full      <= 1'b0;
            vld_p1    <= 1'b0;
        end else begin
            im_we  <= 1'b0;
            im_re  <= 1'b0;
            vld_p1 <= im_re;

            if (startTake) begin
                addr      <= base;
                baseReg   <= base;
                count     <= '0;
                csum      <= '0;
                acc       <= '0;
                rdOffset  <= '0;
                rdCount   <= '0;
                full      <= 1'b0;
                verify_ok <= 1'b0;
                err_kind  <= 1'b0;
                err_ovf   <= 1'b0;
            end

            // Accept -> write stage: registered strobe gives one cycle of latency.
            if (accept) begin
                if (full) begin
                    err_ovf   <= 1'b1;
                    verify_ok <= 1'b0;
                end else if (!wordValid) begin
                    err_kind <= 1'b1;
                end else begin
                    im_we    <= 1'b1;
                    im_addr  <= addr;
                    im_wdata <= word;
                    addr     <= addr + ADDR_ONE;
                    count    <= count + CNT_ONE;
                    csum     <= csum ^ word;
                    // Top word written: addr wraps internally but full blocks any reuse.
                    full     <= (addr == LAST_ADDR);
                end
                if (!full && cmd_last && countNext == '0) verify_ok <= 1'b1;
            end

            // Readback issue stage. The first VERIFY cycle may still carry the
            // final write strobe; reads start a cycle later so strobes never overlap.
            if (state == ST_VERIFY) begin
                if (rdOffset < count) begin
                    im_re    <= 1'b1;
                    im_addr  <= baseReg + rdOffset[ADDR_W-1:0];
                    rdOffset <= rdOffset + CNT_ONE;
                end
                // Readback capture stage: rdata lands one cycle after its strobe.
                if (vld_p1) begin
                    acc     <= acc ^ im_rdata;
                    rdCount <= rdCount + CNT_ONE;
                    if (lastRead) verify_ok <= ((acc ^ im_rdata) == csum);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a small imem model (ADDR_W=4).
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  base;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_kind;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic [15:0] cmd_imm;
    logic [25:0] cmd_target;
    logic        cmd_last;
    logic        im_we, im_re;
    logic [3:0]  im_addr;
    logic [31:0] im_wdata;
    logic [31:0] im_rdata = 32'h0;
    logic [4:0]  count;
    logic        done, verify_ok, err_kind, err_ovf;

    int vecs = 0;
    int errs = 0;

    logic [31:0] mem [16];
    logic        corruptEn = 1'b0;
    logic [3:0]  corruptAddr = 4'd0;

    instr_encoder_loader #(.ADDR_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base(base),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .cmd_target(cmd_target), .cmd_last(cmd_last),
        .im_we(im_we), .im_re(im_re), .im_addr(im_addr), .im_wdata(im_wdata),
        .im_rdata(im_rdata), .count(count), .done(done), .verify_ok(verify_ok),
        .err_kind(err_kind), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (im_we) mem[im_addr] <= im_wdata;
        if (im_re) im_rdata <= mem[im_addr] ^ ((corruptEn && im_addr == corruptAddr) ? 32'h1 : 32'h0);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic startSession(input logic [3:0] b);
        base  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic sendCmd(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [15:0] imm,
                           input logic [25:0] tgt, input logic last);
        cmd_kind = k; cmd_rs = rs; cmd_rt = rt; cmd_rd = rd;
        cmd_imm = imm; cmd_target = tgt; cmd_last = last;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
    endtask

    // Runs until done (bounded), recording readback strobes and addresses.
    task automatic runVerify(input logic [3:0] b, output int nReads, output bit addrOk,
                             output bit overlap, output bit timedOut);
        nReads = 0; addrOk = 1'b1; overlap = 1'b0; timedOut = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (done) begin
                timedOut = 1'b0;
                break;
            end
            if (im_we && im_re) overlap = 1'b1;
            if (im_re) begin
                if (im_addr !== b + nReads[3:0]) addrOk = 1'b0;
                nReads++;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; base = '0; cmd_valid = 1'b0; cmd_kind = '0;
        cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; cmd_imm = '0; cmd_target = '0; cmd_last = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        vecs++;
        if ({im_we, im_re, im_addr, im_wdata, count, done, verify_ok, err_kind, err_ovf, cmd_ready} !== '0) begin
            errs++;
            $display("FAIL reset: we=%b re=%b addr=%0d wdata=%h count=%0d done=%b ok=%b ek=%b eo=%b rdy=%b, all required 0",
                     im_we, im_re, im_addr, im_wdata, count, done, verify_ok, err_kind, err_ovf, cmd_ready);
        end
    endtask

    task automatic test_encode;
        logic [3:0]  kinds [6] = '{4'd0, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};
        logic [4:0]  rss   [6] = '{5'd1, 5'd0, 5'd29, 5'd29, 5'd1, 5'd0};
        logic [4:0]  rts   [6] = '{5'd2, 5'd8, 5'd4, 5'd4, 5'd2, 5'd0};
        logic [4:0]  rds   [6] = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [15:0] imms  [6] = '{16'h0, 16'h1234, 16'hFFFC, 16'hFFFC, 16'hFFFF, 16'h0};
        logic [25:0] tgts  [6] = '{26'h0, 26'h0, 26'h0, 26'h0, 26'h0, 26'h0100000};
        logic [31:0] exps  [6] = '{32'h00221820, 32'h34081234, 32'h8FA4FFFC,
                                   32'hAFA4FFFC, 32'h1022FFFF, 32'h08100000};
        startSession(4'd0);
        vecs++;
        if (cmd_ready !== 1'b1) begin
            errs++;
            $display("FAIL run_ready: cmd_ready=%b, required 1", cmd_ready);
        end
        for (int i = 0; i < 6; i++) begin
            sendCmd(kinds[i], rss[i], rts[i], rds[i], imms[i], tgts[i], 1'b0);
            vecs++;
            if (im_we !== 1'b1 || im_addr !== i[3:0] || im_wdata !== exps[i] || count !== 5'(i + 1)) begin
                errs++;
                $display("FAIL encode_%0d: we=%b addr=%0d wdata=%h count=%0d, required we=1 addr=%0d wdata=%h count=%0d",
                         i, im_we, im_addr, im_wdata, count, i, exps[i], i + 1);
            end
        end
    endtask

    task automatic test_invalid_kind;
        int nReads; bit addrOk, overlap, timedOut;
        sendCmd(4'd14, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        vecs++;
        if (im_we !== 1'b0 || err_kind !== 1'b1 || count !== 5'd6) begin
            errs++;
            $display("FAIL invalid_kind: we=%b err_kind=%b count=%0d, required we=0 err_kind=1 count=6",
                     im_we, err_kind, count);
        end
        sendCmd(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        vecs++;
        if (im_we !== 1'b1 || im_addr !== 4'd6 || im_wdata !== 32'h00221820 || count !== 5'd7) begin
            errs++;
            $display("FAIL after_invalid: we=%b addr=%0d wdata=%h count=%0d, required we=1 addr=6 wdata=00221820 count=7",
                     im_we, im_addr, im_wdata, count);
        end
        sendCmd(4'd2, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        vecs++;
        if (im_we !== 1'b1 || im_addr !== 4'd7 || im_wdata !== 32'h00221821) begin
            errs++;
            $display("FAIL addu_last: we=%b addr=%0d wdata=%h, required we=1 addr=7 wdata=00221821",
                     im_we, im_addr, im_wdata);
        end
        runVerify(4'd0, nReads, addrOk, overlap, timedOut);
        vecs++;
        if (timedOut || nReads != 8 || !addrOk || overlap || verify_ok !== 1'b1 || err_kind !== 1'b1) begin
            errs++;
            $display("FAIL verify_8: timeout=%b reads=%0d addrOk=%b overlap=%b ok=%b err_kind=%b, required 0/8/1/0/1/1",
                     timedOut, nReads, addrOk, overlap, verify_ok, err_kind);
        end
    endtask

    task automatic test_back_to_back;
        int nReads; bit addrOk, overlap, timedOut;
        startSession(4'd0);
        cmd_kind = 4'd0; cmd_rs = 5'd1; cmd_rt = 5'd2; cmd_rd = 5'd3;
        cmd_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cmd_last = (i == 5);
            tick();
            if (i == 5) begin
                cmd_valid = 1'b0;
                cmd_last  = 1'b0;
            end
            vecs++;
            if (im_we !== 1'b1 || im_addr !== i[3:0] || im_wdata !== 32'h00221820) begin
                errs++;
                $display("FAIL b2b_%0d: we=%b addr=%0d wdata=%h, required we=1 addr=%0d wdata=00221820",
                         i, im_we, im_addr, im_wdata, i);
            end
        end
        runVerify(4'd0, nReads, addrOk, overlap, timedOut);
        vecs++;
        if (timedOut || nReads != 6 || !addrOk || overlap || verify_ok !== 1'b1 || count !== 5'd6) begin
            errs++;
            $display("FAIL b2b_verify: timeout=%b reads=%0d addrOk=%b overlap=%b ok=%b count=%0d, required 0/6/1/0/1/6",
                     timedOut, nReads, addrOk, overlap, verify_ok, count);
        end
    endtask

    task automatic test_verify;
        int nReads; bit addrOk, overlap, timedOut;
        for (int pass = 0; pass < 2; pass++) begin
            corruptEn   = (pass == 1);
            corruptAddr = 4'd3;
            startSession(4'd2);
            sendCmd(4'd12, 5'd3, 5'd5, 5'd0, 16'h0007, 26'h0, 1'b0);
            vecs++;
            if (im_we !== 1'b1 || im_addr !== 4'd2 || im_wdata !== 32'h20650007) begin
                errs++;
                $display("FAIL addi_%0d: we=%b addr=%0d wdata=%h, required we=1 addr=2 wdata=20650007",
                         pass, im_we, im_addr, im_wdata);
            end
            sendCmd(4'd1, 5'd4, 5'd5, 5'd6, 16'h0, 26'h0, 1'b0);
            vecs++;
            if (im_wdata !== 32'h00853022 || im_addr !== 4'd3) begin
                errs++;
                $display("FAIL sub_%0d: addr=%0d wdata=%h, required addr=3 wdata=00853022", pass, im_addr, im_wdata);
            end
            sendCmd(4'd5, 5'd7, 5'd8, 5'd9, 16'h0, 26'h0, 1'b1);
            vecs++;
            if (im_wdata !== 32'h00E84824 || im_addr !== 4'd4) begin
                errs++;
                $display("FAIL and_%0d: addr=%0d wdata=%h, required addr=4 wdata=00E84824", pass, im_addr, im_wdata);
            end
            runVerify(4'd2, nReads, addrOk, overlap, timedOut);
            vecs++;
            if (timedOut || nReads != 3 || !addrOk || overlap || verify_ok !== (pass == 0)) begin
                errs++;
                $display("FAIL verify3_%0d: timeout=%b reads=%0d addrOk=%b overlap=%b ok=%b, required 0/3/1/0/%0d",
                         pass, timedOut, nReads, addrOk, overlap, verify_ok, pass == 0);
            end
        end
        corruptEn = 1'b0;
    endtask

    task automatic test_empty_session;
        startSession(4'd5);
        sendCmd(4'd13, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        vecs++;
        if (im_we !== 1'b0 || done !== 1'b1 || verify_ok !== 1'b1 || err_kind !== 1'b1 || count !== 5'd0) begin
            errs++;
            $display("FAIL empty: we=%b done=%b ok=%b err_kind=%b count=%0d, required 0/1/1/1/0",
                     im_we, done, verify_ok, err_kind, count);
        end
    endtask

    task automatic test_overflow;
        startSession(4'd14);
        sendCmd(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        vecs++;
        if (im_we !== 1'b1 || im_addr !== 4'd14) begin
            errs++;
            $display("FAIL ovf_w14: we=%b addr=%0d, required we=1 addr=14", im_we, im_addr);
        end
        sendCmd(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        vecs++;
        if (im_we !== 1'b1 || im_addr !== 4'd15 || err_ovf !== 1'b0) begin
            errs++;
            $display("FAIL ovf_w15: we=%b addr=%0d err_ovf=%b, required we=1 addr=15 err_ovf=0", im_we, im_addr, err_ovf);
        end
        sendCmd(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        vecs++;
        if (im_we !== 1'b0 || err_ovf !== 1'b1 || done !== 1'b1 || verify_ok !== 1'b0 || count !== 5'd2) begin
            errs++;
            $display("FAIL ovf_third: we=%b err_ovf=%b done=%b ok=%b count=%0d, required 0/1/1/0/2",
                     im_we, err_ovf, done, verify_ok, count);
        end
    endtask

    task automatic test_mid_reset;
        startSession(4'd0);
        sendCmd(4'd15, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b0);
        sendCmd(4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vecs++;
        if ({im_we, im_re, im_addr, im_wdata, count, done, verify_ok, err_kind, err_ovf, cmd_ready} !== '0) begin
            errs++;
            $display("FAIL mid_reset: we=%b re=%b addr=%0d wdata=%h count=%0d done=%b ok=%b ek=%b eo=%b rdy=%b, all required 0",
                     im_we, im_re, im_addr, im_wdata, count, done, verify_ok, err_kind, err_ovf, cmd_ready);
        end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_invalid_kind();
        test_back_to_back();
        test_verify();
        test_empty_session();
        test_overflow();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
